// File: rtl/data_mem_banked.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_banked
// Description : Parametrised single-port data memory with a registered
//               1-cycle read, a hardware clear sequencer started by reset and
//               out-of-range access reporting. The word is stored as DATA_W/8
//               independent byte banks, so byte-lane writes need no
//               read-modify-write.
//
//               Optional feature macro: DATA_MEM_BYTE_WE_EN
//                 defined   -> adds we_be[DATA_W/8-1:0]; lane k is written
//                              only when we_be[k]=1
//                 undefined -> every write updates the full word
//
// Parameters  : DATA_W - word width in bits (multiple of 8)
//               ADDR_W - address width in bits
//               DEPTH  - number of words, 1 <= DEPTH <= 2**ADDR_W
//
// Ports       : clk          - clock, rising edge
//               rst          - synchronous reset, active-high
//               datamem_data - write data
//               datamem_addr - read/write address
//               we / re      - write / read enable
//               we_be        - byte write enables (macro builds only)
//               datamem_strm - registered read data, zero when no read
//               rd_valid     - datamem_strm holds last cycle's read result
//               busy         - clear sequence running; accesses ignored
//               addr_err     - pulse for an accepted access with addr>=DEPTH
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_banked #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   datamem_data,
    input  logic [ADDR_W-1:0]   datamem_addr,
    input  logic                we,
    input  logic                re,
`ifdef DATA_MEM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] we_be,
`endif
    output logic [DATA_W-1:0]   datamem_strm,
    output logic                rd_valid,
    output logic                busy,
    output logic                addr_err
);

    localparam int c_lanes = DATA_W / 8;
    // Index width needed to address DEPTH entries of a bank.
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_strm;
    logic              r_rd_valid;
    logic              r_addr_err;

    logic               w_ready;
    logic               w_in_range;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_clr_we;
    logic [c_idx_w-1:0] w_idx;
    logic [c_idx_w-1:0] w_clr_idx;
    logic [c_lanes-1:0] w_lane_en;
    logic [DATA_W-1:0]  w_rd_word;

    assign w_ready    = (r_state == c_st_ready);
    assign w_in_range = ({1'b0, datamem_addr} < c_depth_ext);
    // Reset has priority over everything, so nothing is accepted while rst=1.
    assign w_rd_acc   = !rst && w_ready && re;
    assign w_wr_acc   = !rst && w_ready && we && w_in_range;
    assign w_clr_we   = !rst && !w_ready;
    assign w_idx      = datamem_addr[c_idx_w-1:0];
    assign w_clr_idx  = r_clr_ptr[c_idx_w-1:0];

`ifdef DATA_MEM_BYTE_WE_EN
    assign w_lane_en = we_be;
`else
    assign w_lane_en = '1;
`endif

    // ------------------------------------------------------------------
    // Clear sequencer: zeroes one word per cycle from address 0 upward.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_clear;
            r_clr_ptr <= '0;
        end else if (r_state == c_st_clear) begin
            if (r_clr_ptr == c_last) begin
                r_state <= c_st_ready;
            end
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte banks. The clear write and a user write can never coincide
    // because user writes are only accepted in the ready state. The bank
    // is read combinationally and captured in the output register, which
    // gives read-first behaviour on a same-address write.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_lanes; k++) begin : g_lane
        logic [7:0] r_bank [DEPTH];

        always_ff @(posedge clk) begin
            if (w_clr_we) begin
                r_bank[w_clr_idx] <= 8'h00;
            end else if (w_wr_acc && w_lane_en[k]) begin
                r_bank[w_idx] <= datamem_data[8*k +: 8];
            end
        end

        assign w_rd_word[8*k +: 8] = r_bank[w_idx];
    end

    // ------------------------------------------------------------------
    // Read output and error pulse. The output returns to zero on any
    // cycle without an accepted read; out-of-range reads return zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strm     <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_strm     <= (w_rd_acc && w_in_range) ? w_rd_word : '0;
            // A single pulse covers we and re both out of range.
            r_addr_err <= w_ready && (we || re) && !w_in_range;
        end
    end

    assign datamem_strm = r_strm;
    assign rd_valid     = r_rd_valid;
    assign addr_err     = r_addr_err;
    assign busy         = (r_state == c_st_clear);

endmodule
`default_nettype wire

// File: doc/data_mem_banked.md
Name: data_mem_banked

Overview:
- Parametrised data memory, the successor to the fixed 128x16 data memory in the datapath.
- Configurable width and depth; registered 1-cycle read with a valid flag.
- Reset starts a hardware clear sequencer that zeroes one word per cycle, so the array needs no parallel reset. A busy flag tells the core when the memory is usable.
- Reports out-of-range accesses.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8
ADDR_W, 7, address width in bits
DEPTH, 128, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W

Ports:
clk  input  1  system clock; all activity on the rising edge
rst  input  1  synchronous reset, active-high
datamem_data  input  DATA_W  write data
datamem_addr  input  ADDR_W  read/write address
we  input  1  write enable
re  input  1  read enable
datamem_strm  output  DATA_W  registered read data
rd_valid  output  1  datamem_strm holds data from a read accepted last cycle
busy  output  1  clear sequence in progress; accesses are ignored
addr_err  output  1  one-cycle pulse for an accepted access with addr >= DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - state=CLEAR, clr_ptr=0, busy=1.
  - rd_valid=0, datamem_strm=0, addr_err=0.
  - No array writes.
- CLEAR state, rst=0:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - The cycle that writes clr_ptr=DEPTH-1 moves state to READY.
  - busy is 1 for exactly DEPTH cycles after rst falls, then 0.
- we/re while busy=1: ignored. No write, rd_valid stays 0, addr_err stays 0.
- READY, write: we=1 with addr<DEPTH writes mem[addr] <= datamem_data at the edge.
- READY, read:
  - re=1 with addr<DEPTH gives, on the next cycle, datamem_strm=mem[addr] and rd_valid=1.
  - Latency is exactly 1 cycle.
  - Back-to-back reads are allowed every cycle.
- Idle output: any cycle with no accepted read shows datamem_strm=0 and rd_valid=0 on the following cycle. The output is zero when no read is in progress.
- Simultaneous we and re to the same address: read-first. datamem_strm returns the old contents; the new data is visible from the next read.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - The write is dropped.
  - The read returns datamem_strm=0 with rd_valid=1.
  - addr_err pulses 1 on the following cycle for either case.
  - we and re both out of range in the same cycle produce a single pulse.
- Reset mid-operation:
  - rst during CLEAR restarts the sequence from address 0.
  - rst during READY discards any pending read result. rd_valid=0 next cycle.
- No wrap-around: addresses do not wrap; out-of-range handling above applies.
- State encoding: 1 bit (CLEAR, READY). clr_ptr is ADDR_W bits wide and compares against DEPTH-1.

Optional Feature:
- Macro: DATA_MEM_BYTE_WE_EN.
- Defined:
  - Adds input port we_be, width DATA_W/8.
  - When we=1, byte lane k (bits 8k+7:8k) is written only if we_be[k]=1; other lanes keep their value.
  - we=1 with we_be=0 writes nothing but still raises addr_err if out of range.
- Undefined: port absent; every write updates the full word.
- Clear sequencer and read path are identical in both builds.

Test Plan:
- Clear timing: DEPTH=128; preload mem[5]=16'hBEEF, assert rst 3 cycles, release -> busy=1 for exactly 128 cycles then 0. Read addr 5 -> datamem_strm=16'h0000, rd_valid=1 one cycle after re.
- Write/read: write 16'h1234 to addr 10, then re to addr 10 next cycle -> datamem_strm=16'h1234, rd_valid=1 one cycle later. With re=0 the following cycle -> datamem_strm=0, rd_valid=0.
- Same-cycle collision: mem[20]=16'h00AA; we=1, re=1, addr=20, data=16'h5555 -> datamem_strm=16'h00AA. Next read of 20 -> 16'h5555.
- Out of range: DEPTH=100, ADDR_W=7. Write 16'hFFFF to addr 110 -> addr_err=1 for one cycle. Read addr 110 -> datamem_strm=0, rd_valid=1. mem[0..99] unchanged.
- Reset mid-clear: assert rst at clear cycle 50 for 1 cycle -> busy stays 1 for a further full DEPTH cycles after release; we/re during busy have no effect, addr_err=0.
- Byte enables (DATA_MEM_BYTE_WE_EN defined): mem[3]=16'h1122. Write 16'hAABB with we_be=2'b01 -> read gives 16'h11BB. Then we_be=2'b10 with 16'hCCDD -> read gives 16'hCCBB.
